// File: rtl/sb_tx_arbiter_if.sv
// Sideband TX arbiter bus: requester capture, status pulses and the serializer handshake.
//   flush_i          drop every pending message, return to IDLE
//   req_valid_i      one-cycle message pulse per requester (N bits)
//   req_msg_i        flattened headers, requester i at [i*MSG_W +: MSG_W]
//   req_data_i       flattened payloads, requester i at [i*DATA_W +: DATA_W]
//   req_pending_o    requester i has a buffered, unsent message
//   req_sent_o       pulse: requester i's message was accepted by TX
//   req_overflow_o   pulse: requester i's buffered message was overwritten
//   tx_msg_o/tx_data_o  message and payload presented to the SB TX serializer
//   tx_valid_o       one-cycle send pulse to the serializer
//   tx_sendNext_i    serializer has consumed the current message
//   tx_busy_o        arbiter is waiting on the serializer
interface sb_tx_arbiter_if #(
    parameter int unsigned N      = 4,
    parameter int unsigned MSG_W  = 64,
    parameter int unsigned DATA_W = 64
);
    logic                  flush_i;
    logic [N-1:0]          req_valid_i;
    logic [N*MSG_W-1:0]    req_msg_i;
    logic [N*DATA_W-1:0]   req_data_i;
    logic [N-1:0]          req_pending_o;
    logic [N-1:0]          req_sent_o;
    logic [N-1:0]          req_overflow_o;
    logic [MSG_W-1:0]      tx_msg_o;
    logic [DATA_W-1:0]     tx_data_o;
    logic                  tx_valid_o;
    logic                  tx_sendNext_i;
    logic                  tx_busy_o;

    // Requesters and serializer side
    modport master (
        output flush_i, req_valid_i, req_msg_i, req_data_i, tx_sendNext_i,
        input  req_pending_o, req_sent_o, req_overflow_o,
               tx_msg_o, tx_data_o, tx_valid_o, tx_busy_o
    );

    // Arbiter side
    modport slave (
        input  flush_i, req_valid_i, req_msg_i, req_data_i, tx_sendNext_i,
        output req_pending_o, req_sent_o, req_overflow_o,
               tx_msg_o, tx_data_o, tx_valid_o, tx_busy_o
    );
endinterface

// File: rtl/sb_tx_arbiter.sv
// Round-robin arbiter sharing the sideband TX channel between N LTSM controllers.
// Each requester has a single-entry buffer; the granted requester also has a
// shadow entry so a new message arriving mid-transfer never disturbs the copy
// on the wire. An unacknowledged message is re-pulsed every RESEND_CYC cycles.
//   clk_100MHz  clock
//   reset       synchronous, active-high
//   bus         sb_tx_arbiter_if.slave (requests, status pulses, TX handshake)
module sb_tx_arbiter #(
    parameter int unsigned N          = 4,
    parameter int unsigned MSG_W      = 64,
    parameter int unsigned DATA_W     = 64,
    parameter int unsigned RESEND_CYC = 800
) (
    input  logic           clk_100MHz,
    input  logic           reset,
    sb_tx_arbiter_if.slave bus
);
    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned CNT_W = (RESEND_CYC > 1) ? $clog2(RESEND_CYC) : 1;

    typedef enum logic [0:0] {ST_IDLE, ST_WAIT} state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    grant_q, grant_d;
    logic [IDX_W-1:0]    last_q, last_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [N-1:0]        pending_q, pending_d;
    logic [N-1:0]        sent_q, sent_d;
    logic [N-1:0]        ovf_q, ovf_d;
    logic [MSG_W-1:0]    buf_msg_q [N];
    logic [MSG_W-1:0]    buf_msg_d [N];
    logic [DATA_W-1:0]   buf_data_q [N];
    logic [DATA_W-1:0]   buf_data_d [N];
    logic                sh_valid_q, sh_valid_d;
    logic [MSG_W-1:0]    sh_msg_q, sh_msg_d;
    logic [DATA_W-1:0]   sh_data_q, sh_data_d;
    logic [MSG_W-1:0]    tx_msg_q, tx_msg_d;
    logic [DATA_W-1:0]   tx_data_q, tx_data_d;
    logic                tx_valid_q, tx_valid_d;
    logic                busy_q;

    logic                sel_found;
    logic [IDX_W-1:0]    sel_idx;
    logic [IDX_W-1:0]    cand;
    logic                complete;
    logic                lock;
    logic [IDX_W-1:0]    lock_idx;

    // Round-robin pick: first pending index after last_grant, wrapping modulo N
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            cand = IDX_W'((32'(last_q) + k) % N);
            if (!sel_found && pending_q[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    // Next-state, buffer capture and output values
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        last_d     = last_q;
        cnt_d      = cnt_q;
        pending_d  = pending_q;
        buf_msg_d  = buf_msg_q;
        buf_data_d = buf_data_q;
        sh_valid_d = sh_valid_q;
        sh_msg_d   = sh_msg_q;
        sh_data_d  = sh_data_q;
        tx_msg_d   = tx_msg_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = 1'b0;
        sent_d     = '0;
        ovf_d      = '0;
        complete   = 1'b0;
        lock       = 1'b0;
        lock_idx   = grant_q;

        if (bus.flush_i) begin
            pending_d  = '0;
            sh_valid_d = 1'b0;
            cnt_d      = '0;
            state_d    = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (sel_found) begin
                        tx_msg_d   = buf_msg_q[sel_idx];
                        tx_data_d  = buf_data_q[sel_idx];
                        tx_valid_d = 1'b1;
                        grant_d    = sel_idx;
                        cnt_d      = '0;
                        state_d    = ST_WAIT;
                        // Buffer is being sent this cycle: a same-cycle request goes to the shadow
                        lock       = 1'b1;
                        lock_idx   = sel_idx;
                    end
                end
                ST_WAIT: begin
                    if (bus.tx_sendNext_i) begin
                        complete        = 1'b1;
                        sent_d[grant_q] = 1'b1;
                        last_d          = grant_q;
                        state_d         = ST_IDLE;
                        // A shadowed message becomes the buffer and stays pending
                        if (sh_valid_q) begin
                            buf_msg_d[grant_q]  = sh_msg_q;
                            buf_data_d[grant_q] = sh_data_q;
                            sh_valid_d          = 1'b0;
                        end else begin
                            pending_d[grant_q] = 1'b0;
                        end
                    end else begin
                        lock = 1'b1;
                        if (cnt_q == CNT_W'(RESEND_CYC - 1)) begin
                            tx_valid_d = 1'b1;
                            cnt_d      = '0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase

            for (int unsigned i = 0; i < N; i++) begin
                if (bus.req_valid_i[IDX_W'(i)]) begin
                    if (complete && (IDX_W'(i) == grant_q)) begin
                        // Old copy retires this cycle; new one takes the freed buffer
                        ovf_d[IDX_W'(i)]      = sh_valid_q;
                        buf_msg_d[IDX_W'(i)]  = bus.req_msg_i[i*MSG_W +: MSG_W];
                        buf_data_d[IDX_W'(i)] = bus.req_data_i[i*DATA_W +: DATA_W];
                        pending_d[IDX_W'(i)]  = 1'b1;
                    end else if (lock && (IDX_W'(i) == lock_idx)) begin
                        ovf_d[IDX_W'(i)] = sh_valid_q;
                        sh_valid_d       = 1'b1;
                        sh_msg_d         = bus.req_msg_i[i*MSG_W +: MSG_W];
                        sh_data_d        = bus.req_data_i[i*DATA_W +: DATA_W];
                    end else begin
                        ovf_d[IDX_W'(i)]      = pending_q[IDX_W'(i)];
                        buf_msg_d[IDX_W'(i)]  = bus.req_msg_i[i*MSG_W +: MSG_W];
                        buf_data_d[IDX_W'(i)] = bus.req_data_i[i*DATA_W +: DATA_W];
                        pending_d[IDX_W'(i)]  = 1'b1;
                    end
                end
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            last_q     <= IDX_W'(N - 1);
            cnt_q      <= '0;
            pending_q  <= '0;
            sent_q     <= '0;
            ovf_q      <= '0;
            sh_valid_q <= 1'b0;
            sh_msg_q   <= '0;
            sh_data_q  <= '0;
            tx_msg_q   <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            for (int unsigned i = 0; i < N; i++) begin
                buf_msg_q[i]  <= '0;
                buf_data_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
            pending_q  <= pending_d;
            sent_q     <= sent_d;
            ovf_q      <= ovf_d;
            sh_valid_q <= sh_valid_d;
            sh_msg_q   <= sh_msg_d;
            sh_data_q  <= sh_data_d;
            tx_msg_q   <= tx_msg_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            busy_q     <= (state_d != ST_IDLE);
            buf_msg_q  <= buf_msg_d;
            buf_data_q <= buf_data_d;
        end
    end

    assign bus.req_pending_o  = pending_q;
    assign bus.req_sent_o     = sent_q;
    assign bus.req_overflow_o = ovf_q;
    assign bus.tx_msg_o       = tx_msg_q;
    assign bus.tx_data_o      = tx_data_q;
    assign bus.tx_valid_o     = tx_valid_q;
    assign bus.tx_busy_o      = busy_q;
endmodule

// File: tb/tb_sb_tx_arbiter.sv
// Bench for sb_tx_arbiter: directed scenarios then random traffic. A transaction-level
// reference model (absolute cycle stamps, per-requester arrays) pushes expected events
// into queues; a negedge monitor pops them whenever the DUT presents an output.
module tb_sb_tx_arbiter;
    localparam int unsigned N      = 4;
    localparam int unsigned MSG_W  = 64;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned RESEND = 10;

    logic clk_100MHz = 1'b0;
    logic reset      = 1'b1;
    always #5 clk_100MHz = ~clk_100MHz;

    sb_tx_arbiter_if #(.N(N), .MSG_W(MSG_W), .DATA_W(DATA_W)) bus ();

    sb_tx_arbiter #(.N(N), .MSG_W(MSG_W), .DATA_W(DATA_W), .RESEND_CYC(RESEND)) dut (
        .clk_100MHz (clk_100MHz),
        .reset      (reset),
        .bus        (bus)
    );

    typedef struct { int unsigned stamp; logic [N-1:0] pend; logic busy; logic zero_tx; } status_t;
    typedef struct { int unsigned stamp; logic [MSG_W-1:0] msg; logic [DATA_W-1:0] data; } tx_t;
    typedef struct { int unsigned stamp; logic [N-1:0] vec; } vec_t;

    status_t st_q [$];
    tx_t     tx_q [$];
    vec_t    sent_q [$];
    vec_t    ovf_q [$];

    int unsigned pcnt = 0;
    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    always @(posedge clk_100MHz) pcnt <= pcnt + 1;

    // Driver-side message values
    logic [MSG_W-1:0]  drv_msg  [N];
    logic [DATA_W-1:0] drv_data [N];
    bit                sn_random = 1'b0;
    int unsigned       sn_delay  = 3;

    // Reference model state
    logic [N-1:0]      m_pend = '0;
    logic [MSG_W-1:0]  m_msg  [N];
    logic [DATA_W-1:0] m_data [N];
    bit                m_infl = 1'b0;
    int                m_g    = 0;
    int                m_last = N - 1;
    bit                m_shv  = 1'b0;
    logic [MSG_W-1:0]  m_shm;
    logic [DATA_W-1:0] m_shd;
    logic [MSG_W-1:0]  m_cur_msg;
    logic [DATA_W-1:0] m_cur_data;
    int unsigned       m_next_tx = 0;
    int unsigned       m_grant_stamp = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, pcnt, act, exp);
        end
    endtask

    task automatic unexpected(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s at cycle %0d: DUT pulsed with nothing expected", nm, pcnt);
    endtask

    // Model one clock edge; s is the cycle stamp at which the resulting outputs are visible
    task automatic model(input int unsigned s, input logic rst, input logic fl,
                         input logic [N-1:0] rv, input logic sn);
        logic [N-1:0] sent;
        logic [N-1:0] ovf;
        bit done;
        bit old_shv;
        int f;
        sent = '0;
        ovf  = '0;
        if (rst) begin
            m_pend = '0; m_infl = 1'b0; m_shv = 1'b0; m_last = N - 1;
            st_q.push_back('{s, '0, 1'b0, 1'b1});
            return;
        end
        if (fl) begin
            m_pend = '0; m_infl = 1'b0; m_shv = 1'b0;
            st_q.push_back('{s, '0, 1'b0, 1'b0});
            return;
        end
        done    = 1'b0;
        old_shv = m_shv;
        if (m_infl) begin
            if (sn) begin
                done = 1'b1; sent[m_g] = 1'b1; m_last = m_g; m_infl = 1'b0;
                if (m_shv) begin
                    m_msg[m_g] = m_shm; m_data[m_g] = m_shd; m_shv = 1'b0;
                end else begin
                    m_pend[m_g] = 1'b0;
                end
            end else if (s == m_next_tx) begin
                tx_q.push_back('{s, m_cur_msg, m_cur_data});
                m_next_tx = s + RESEND;
            end
        end else begin
            f = -1;
            for (int k = 1; k <= N; k++)
                if (f < 0 && m_pend[(m_last + k) % N]) f = (m_last + k) % N;
            if (f >= 0) begin
                m_g = f; m_infl = 1'b1;
                m_cur_msg = m_msg[f]; m_cur_data = m_data[f];
                m_grant_stamp = s; m_next_tx = s + RESEND;
                tx_q.push_back('{s, m_cur_msg, m_cur_data});
            end
        end
        for (int i = 0; i < N; i++) begin
            if (rv[i]) begin
                if (done && i == m_g) begin
                    ovf[i] = old_shv; m_msg[i] = drv_msg[i]; m_data[i] = drv_data[i]; m_pend[i] = 1'b1;
                end else if (m_infl && i == m_g) begin
                    ovf[i] = m_shv; m_shv = 1'b1; m_shm = drv_msg[i]; m_shd = drv_data[i];
                end else begin
                    ovf[i] = m_pend[i]; m_msg[i] = drv_msg[i]; m_data[i] = drv_data[i]; m_pend[i] = 1'b1;
                end
            end
        end
        st_q.push_back('{s, m_pend, m_infl, 1'b0});
        if (sent != '0) sent_q.push_back('{s, sent});
        if (ovf != '0)  ovf_q.push_back('{s, ovf});
    endtask

    // One clock of stimulus; the serializer's sendNext is derived from the model's grant time
    task automatic cyc(input logic [N-1:0] rv, input logic fl = 1'b0, input logic rst = 1'b0);
        logic sn;
        @(negedge clk_100MHz);
        if (sn_random) sn = ($urandom_range(0, 2) == 0);
        else           sn = m_infl && (pcnt == m_grant_stamp + sn_delay);
        reset             = rst;
        bus.flush_i       = fl;
        bus.req_valid_i   = rv;
        bus.tx_sendNext_i = sn;
        for (int i = 0; i < N; i++) begin
            bus.req_msg_i[i*MSG_W +: MSG_W]    = drv_msg[i];
            bus.req_data_i[i*DATA_W +: DATA_W] = drv_data[i];
        end
        model(pcnt + 1, rst, fl, rv, sn);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc('0);
    endtask

    task automatic set_msg(input int i, input logic [MSG_W-1:0] m);
        drv_msg[i]  = m;
        drv_data[i] = m ^ 64'hDA7A_0000_0000_0000;
    endtask

    // Monitor: pop and compare whenever the DUT presents something
    always @(negedge clk_100MHz) begin
        status_t s;
        tx_t     t;
        vec_t    v;
        if (st_q.size() != 0 && st_q[0].stamp == pcnt) begin
            s = st_q.pop_front();
            chk("pending", 64'(bus.req_pending_o), 64'(s.pend));
            chk("busy", 64'(bus.tx_busy_o), 64'(s.busy));
            if (s.zero_tx) begin
                chk("reset_msg", 64'(bus.tx_msg_o), 64'h0);
                chk("reset_data", 64'(bus.tx_data_o), 64'h0);
            end
        end
        if (bus.tx_valid_o === 1'b1) begin
            if (tx_q.size() == 0) unexpected("tx_valid");
            else begin
                t = tx_q.pop_front();
                chk("tx_time", 64'(pcnt), 64'(t.stamp));
                chk("tx_msg", 64'(bus.tx_msg_o), 64'(t.msg));
                chk("tx_data", 64'(bus.tx_data_o), 64'(t.data));
            end
        end
        if ((|bus.req_sent_o) === 1'b1) begin
            if (sent_q.size() == 0) unexpected("req_sent");
            else begin
                v = sent_q.pop_front();
                chk("sent_time", 64'(pcnt), 64'(v.stamp));
                chk("sent_vec", 64'(bus.req_sent_o), 64'(v.vec));
            end
        end
        if ((|bus.req_overflow_o) === 1'b1) begin
            if (ovf_q.size() == 0) unexpected("req_overflow");
            else begin
                v = ovf_q.pop_front();
                chk("ovf_time", 64'(pcnt), 64'(v.stamp));
                chk("ovf_vec", 64'(bus.req_overflow_o), 64'(v.vec));
            end
        end
    end

    initial begin
        logic [N-1:0] rv;
        bus.flush_i = 1'b0; bus.req_valid_i = '0; bus.tx_sendNext_i = 1'b0;
        bus.req_msg_i = '0; bus.req_data_i = '0;
        for (int i = 0; i < N; i++) begin
            drv_msg[i] = '0; drv_data[i] = '0; m_msg[i] = '0; m_data[i] = '0;
        end

        repeat (3) cyc('0, 1'b0, 1'b1);
        idle(2);

        // Single request
        set_msg(1, 64'hA5); cyc(4'b0010); idle(10);

        // Fairness: all four together, then 0 and 3
        for (int i = 0; i < N; i++) set_msg(i, 64'h100 + 64'(i));
        cyc(4'b1111); idle(30);
        set_msg(0, 64'h200); set_msg(3, 64'h203); cyc(4'b1001); idle(15);

        // Overflow while requester 0 holds the grant
        set_msg(0, 64'h300); cyc(4'b0001); idle(2);
        set_msg(2, 64'h11); cyc(4'b0100);
        set_msg(2, 64'h22); cyc(4'b0100); idle(20);

        // Resend with no acknowledge for 25 cycles
        sn_delay = 25;
        set_msg(3, 64'hC3); cyc(4'b1000); idle(35);
        sn_delay = 3;

        // Shadow capture during WAIT
        set_msg(1, 64'h33); cyc(4'b0010); idle(2);
        set_msg(1, 64'h44); cyc(4'b0010); idle(15);

        // Flush during WAIT with others pending
        sn_delay = 25;
        for (int i = 0; i < N; i++) set_msg(i, 64'h500 + 64'(i));
        cyc(4'b1111); idle(3);
        cyc('0, 1'b1); idle(5);

        // Reset mid-WAIT restores requester 0 priority
        sn_delay = 3;
        set_msg(0, 64'h600); cyc(4'b0001); idle(10);
        sn_delay = 25;
        set_msg(2, 64'h602); cyc(4'b0100); idle(3);
        cyc('0, 1'b0, 1'b1);
        sn_delay = 3;
        set_msg(0, 64'h700); set_msg(1, 64'h701); cyc(4'b0011); idle(15);

        // Random traffic
        sn_random = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            rv = '0;
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 5) == 0) begin
                    rv[i] = 1'b1;
                    set_msg(i, {$urandom, $urandom});
                end
            end
            if ($urandom_range(0, 399) == 0)      cyc(rv, 1'b0, 1'b1);
            else if ($urandom_range(0, 149) == 0) cyc(rv, 1'b1);
            else                                  cyc(rv);
        end

        // Drain
        sn_random = 1'b0;
        sn_delay  = 3;
        idle(120);
        @(negedge clk_100MHz);
        @(negedge clk_100MHz);
        chk("tx_left", 64'(tx_q.size()), 64'h0);
        chk("sent_left", 64'(sent_q.size()), 64'h0);
        chk("ovf_left", 64'(ovf_q.size()), 64'h0);
        chk("pending_drained", 64'(bus.req_pending_o), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
